// File: rtl/alu_result_stage.sv
// Write-back stage behind the add/sub ALU: accumulator, flags, result FIFO and drop counter.
// Optional overflow flag (ports a_msb, b_msb, flag_v) is built when ALU_OVF_FLAG_EN is defined.
module alu_result_stage #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cap_valid,
  output logic                     cap_ready,
  input  logic [W-1:0]             alu_result,
  input  logic                     alu_carry,
  input  logic                     alu_op,
  input  logic                     clr,
  output logic [W-1:0]             acc,
  output logic                     flag_c,
  output logic                     flag_z,
`ifdef ALU_OVF_FLAG_EN
  input  logic                     a_msb,
  input  logic                     b_msb,
  output logic                     flag_v,
`endif
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [W-1:0]             out_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic [7:0]               drop_cnt
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [W-1:0] result;
    logic         carry;
  } cap_t;

  cap_t            cap;
  logic [W-1:0]    mem [DEPTH];
  logic [AW-1:0]   rd_ptr, wr_ptr;
  logic [CW-1:0]   cnt;
  logic [W-1:0]    last_q;
  logic            full, empty, push, pop, drop;

  assign cap   = '{result: alu_result, carry: alu_carry};
  assign full  = (cnt == CW'(DEPTH));
  assign empty = (cnt == '0);

  // Handshake outputs come from registered occupancy only; no full bypass.
  assign cap_ready = !full;
  assign out_valid = !empty;
  assign push      = cap_valid && !full;
  assign pop       = !empty && out_ready;
  assign drop      = cap_valid && full;
  assign count     = cnt;

  // Empty FIFO keeps presenting the last value that was read out.
  assign out_data  = empty ? last_q : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      flag_c <= 1'b0;
      flag_z <= 1'b1;
    end else if (clr) begin
      acc    <= '0;
      flag_c <= 1'b0;
      flag_z <= 1'b1;
    end else if (push) begin
      acc    <= cap.result;
      flag_c <= cap.carry;
      flag_z <= (cap.result == '0);
    end
  end

`ifdef ALU_OVF_FLAG_EN
  logic ovf;
  always_comb begin
    ovf = 1'b0;
    if (alu_op) ovf = (a_msb != b_msb) && (alu_result[W-1] != a_msb);
    else        ovf = (a_msb == b_msb) && (alu_result[W-1] != a_msb);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    flag_v <= 1'b0;
    else if (clr)  flag_v <= 1'b0;
    else if (push) flag_v <= ovf;
  end
`else
  logic unused_op;
  assign unused_op = alu_op;
`endif

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= cap.result;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
      last_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
        last_q <= mem[rd_ptr];
      end
      unique case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         drop_cnt <= '0;
    else if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
  end

endmodule
